// File: rtl/num_pkg.sv
// Shared numeric helpers for the rounding adder datapath.
//   sum_width - width of an exact sum of n operands of a given width
//   sat_max   - largest representable value of a w-bit signed/unsigned word
//   sat_min   - smallest representable value of a w-bit signed/unsigned word
// sat_max/sat_min return SAT_MAX_W-bit patterns; callers keep the low w bits.
package num_pkg;

    localparam int SAT_MAX_W = 64;

    localparam logic [SAT_MAX_W:0] ONE_WIDE = (SAT_MAX_W + 1)'(1);

    function automatic int sum_width(input int width, input int n);
        return width + $clog2(n);
    endfunction

    function automatic logic [SAT_MAX_W-1:0] sat_max(input int w, input bit is_signed);
        logic [SAT_MAX_W:0] v;
        v = is_signed ? (ONE_WIDE << (w - 1)) : (ONE_WIDE << w);
        v = v - ONE_WIDE;
        return v[SAT_MAX_W-1:0];
    endfunction

    // Signed minimum is the lone-MSB pattern 100..0 once truncated to w bits.
    function automatic logic [SAT_MAX_W-1:0] sat_min(input int w, input bit is_signed);
        logic [SAT_MAX_W:0] v;
        v = is_signed ? (ONE_WIDE << (w - 1)) : '0;
        return v[SAT_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/round_half_even_sat.sv
// Registered round-half-to-even and saturate stage.
// Drops FRAC_DROP LSBs from the incoming full-precision sum (or, in fractional
// mode with a negative FRAC_DROP, appends -FRAC_DROP zero LSBs), rounds to
// nearest with ties to even, then clamps to the WIDTH_OUT output range.
// Ports:
//   i_clk  - rising-edge clock
//   i_rst  - synchronous active-high reset, clears o_dout
//   i_ena  - stage enable; low holds o_dout
//   i_sum  - WIDTH_IN-bit full-precision sum
//   o_dout - WIDTH_OUT-bit rounded, saturated result
module round_half_even_sat
    import num_pkg::*;
#(
    parameter int WIDTH_IN    = 10,
    parameter int WIDTH_OUT   = 8,
    parameter int IS_SIGNED   = 1,
    parameter int IS_FRACTION = 0,
    parameter int FRAC_DROP   = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_ena,
    input  logic [WIDTH_IN-1:0]  i_sum,
    output logic [WIDTH_OUT-1:0] o_dout
);

    // Width of the value left after dropping or padding LSBs. Integer mode
    // with nothing to drop simply passes the sum through at its own width.
    localparam int KW = (FRAC_DROP > 0 || IS_FRACTION != 0) ? WIDTH_IN - FRAC_DROP
                                                             : WIDTH_IN;
    // One extra bit so the rounding carry never wraps before saturation.
    localparam int RW = KW + 1;

    logic [KW-1:0]        w_kept;
    logic                 w_inc;
    logic [RW-1:0]        w_round;
    logic [WIDTH_OUT-1:0] w_sat;
    logic [WIDTH_OUT-1:0] r_dout;

    generate
        if (FRAC_DROP > 0) begin : g_round
            logic w_guard;
            logic w_sticky;

            // Truncating two's-complement bits is a floor, so guard/sticky
            // describe the non-negative remainder and ties resolve to the even
            // neighbour symmetrically for negative values too.
            assign w_kept  = i_sum[WIDTH_IN-1:FRAC_DROP];
            assign w_guard = i_sum[FRAC_DROP-1];

            if (FRAC_DROP > 1) begin : g_sticky
                assign w_sticky = |i_sum[FRAC_DROP-2:0];
            end else begin : g_no_sticky
                assign w_sticky = 1'b0;
            end

            assign w_inc = w_guard & (w_sticky | w_kept[0]);
        end else if (IS_FRACTION != 0 && FRAC_DROP < 0) begin : g_pad
            // Output has more fractional bits than the input: scale up.
            assign w_kept = {i_sum, {(-FRAC_DROP){1'b0}}};
            assign w_inc  = 1'b0;
        end else begin : g_pass
            assign w_kept = i_sum;
            assign w_inc  = 1'b0;
        end
    endgenerate

    assign w_round = {(IS_SIGNED != 0) & w_kept[KW-1], w_kept} + RW'(w_inc);

    generate
        if (RW <= WIDTH_OUT) begin : g_fit
            always_comb begin
                w_sat = {WIDTH_OUT{(IS_SIGNED != 0) & w_round[RW-1]}};
                w_sat[RW-1:0] = w_round;
            end
        end else if (IS_SIGNED != 0) begin : g_sat_s
            localparam logic [WIDTH_OUT-1:0] SAT_HI = WIDTH_OUT'(sat_max(WIDTH_OUT, 1'b1));
            localparam logic [WIDTH_OUT-1:0] SAT_LO = WIDTH_OUT'(sat_min(WIDTH_OUT, 1'b1));

            logic [RW-WIDTH_OUT:0] w_top;

            // In range only if every bit from the output sign bit upward agrees.
            assign w_top = w_round[RW-1:WIDTH_OUT-1];

            always_comb begin
                if ((&w_top) || (~|w_top)) begin
                    w_sat = w_round[WIDTH_OUT-1:0];
                end else if (w_round[RW-1]) begin
                    w_sat = SAT_LO;
                end else begin
                    w_sat = SAT_HI;
                end
            end
        end else begin : g_sat_u
            localparam logic [WIDTH_OUT-1:0] SAT_HI = WIDTH_OUT'(sat_max(WIDTH_OUT, 1'b0));

            always_comb begin
                if (|w_round[RW-1:WIDTH_OUT]) begin
                    w_sat = SAT_HI;
                end else begin
                    w_sat = w_round[WIDTH_OUT-1:0];
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dout <= '0;
        end else if (i_ena) begin
            r_dout <= w_sat;
        end
    end

    assign o_dout = r_dout;

endmodule

// File: rtl/multi_input_round_adder.sv
// Sums NUM_INPUT operands at full precision, then rounds half-to-even and
// saturates down to WIDTH_OUT bits. Two registered stages, two enabled edges
// of latency; ena low stalls the whole pipe.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, clears both pipeline stages
//   ena  - pipeline enable
//   din  - NUM_INPUT operands of WIDTH_IN bits (signed when IS_SIGNED=1)
//   dout - WIDTH_OUT-bit rounded, saturated sum
module multi_input_round_adder
    import num_pkg::*;
#(
    parameter int NUM_INPUT   = 2,
    parameter int WIDTH_IN    = 8,
    parameter int WIDTH_OUT   = 8,
    parameter int IS_SIGNED   = 1,
    parameter int IS_FRACTION = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [WIDTH_IN-1:0]  din [NUM_INPUT],
    output logic [WIDTH_OUT-1:0] dout
);

    localparam int WT = sum_width(WIDTH_IN, NUM_INPUT);

    // Integer mode keeps the MSBs of the full sum; fractional mode keeps the
    // binary point aligned with the input MSB, so only input LSBs are dropped
    // and the growth bits are left for the saturator.
    localparam int DROP = (IS_FRACTION != 0) ? WIDTH_IN - WIDTH_OUT : WT - WIDTH_OUT;

    generate
        if (NUM_INPUT < 1) begin : g_err_num
            $error("multi_input_round_adder: NUM_INPUT must be >= 1");
        end
        if (WIDTH_IN < 1) begin : g_err_win
            $error("multi_input_round_adder: WIDTH_IN must be > 0");
        end
        if (WIDTH_OUT < 1 || WIDTH_OUT > SAT_MAX_W) begin : g_err_wout
            $error("multi_input_round_adder: WIDTH_OUT must be in 1..64");
        end
        if (IS_SIGNED != 0 && IS_SIGNED != 1) begin : g_err_sgn
            $error("multi_input_round_adder: IS_SIGNED must be 0 or 1");
        end
        if (IS_FRACTION != 0 && IS_FRACTION != 1) begin : g_err_frac
            $error("multi_input_round_adder: IS_FRACTION must be 0 or 1");
        end
    endgenerate

    logic [WT-1:0] w_ext;
    logic [WT-1:0] w_sum;
    logic [WT-1:0] r_sum;

    // WT carries clog2(NUM_INPUT) growth bits, so the modular sum is exact.
    always_comb begin
        w_sum = '0;
        w_ext = '0;
        for (int i = 0; i < NUM_INPUT; i++) begin
            w_ext = {WT{(IS_SIGNED != 0) & din[i][WIDTH_IN-1]}};
            w_ext[WIDTH_IN-1:0] = din[i];
            w_sum = w_sum + w_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= '0;
        end else if (ena) begin
            r_sum <= w_sum;
        end
    end

    round_half_even_sat #(
        .WIDTH_IN    (WT),
        .WIDTH_OUT   (WIDTH_OUT),
        .IS_SIGNED   (IS_SIGNED),
        .IS_FRACTION (IS_FRACTION),
        .FRAC_DROP   (DROP)
    ) u_round_sat (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_ena  (ena),
        .i_sum  (r_sum),
        .o_dout (dout)
    );

endmodule

// File: tb/tb_multi_input_round_adder.sv
// Four configurations of the rounding adder driven side by side:
//   A: integer signed,   N=4, 8 -> 8 (drop 2)
//   B: fractional signed, N=2, 8 -> 8 (drop 0, growth saturated)
//   C: fractional signed, N=2, 8 -> 4 (drop 4)
//   D: integer unsigned, N=3, 4 -> 4 (drop 2)
module tb_multi_input_round_adder;

    logic clk = 1'b0;
    logic rst;
    logic ena;

    logic [7:0] din_a [4];
    logic [7:0] din_b [2];
    logic [7:0] din_c [2];
    logic [3:0] din_d [3];
    logic [7:0] dout_a;
    logic [7:0] dout_b;
    logic [3:0] dout_c;
    logic [3:0] dout_d;

    int n_checks = 0;
    int n_fail   = 0;

    // Value-level model: stage contents as plain integers.
    longint s_a, s_b, s_c, s_d;
    longint o_a, o_b, o_c, o_d;

    always #5 clk = ~clk;

    multi_input_round_adder #(.NUM_INPUT(4), .WIDTH_IN(8), .WIDTH_OUT(8), .IS_SIGNED(1), .IS_FRACTION(0))
        u_a (.clk(clk), .rst(rst), .ena(ena), .din(din_a), .dout(dout_a));
    multi_input_round_adder #(.NUM_INPUT(2), .WIDTH_IN(8), .WIDTH_OUT(8), .IS_SIGNED(1), .IS_FRACTION(1))
        u_b (.clk(clk), .rst(rst), .ena(ena), .din(din_b), .dout(dout_b));
    multi_input_round_adder #(.NUM_INPUT(2), .WIDTH_IN(8), .WIDTH_OUT(4), .IS_SIGNED(1), .IS_FRACTION(1))
        u_c (.clk(clk), .rst(rst), .ena(ena), .din(din_c), .dout(dout_c));
    multi_input_round_adder #(.NUM_INPUT(3), .WIDTH_IN(4), .WIDTH_OUT(4), .IS_SIGNED(0), .IS_FRACTION(0))
        u_d (.clk(clk), .rst(rst), .ena(ena), .din(din_d), .dout(dout_d));

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint wrap(input longint v, input int w);
        return v & ((64'sd1 <<< w) - 64'sd1);
    endfunction

    // Divide by 2^drop with ties to even (or scale up when fractional and
    // drop<0), then clamp to the w-bit range.
    function automatic longint round_sat(input longint s, input int drop, input bit frac,
                                         input int w, input bit sgn);
        longint p, q, r, v, lo, hi;
        v = s;
        if (drop > 0) begin
            p = 64'sd1 <<< drop;
            q = s / p;
            if ((s % p) != 0 && s < 0) q = q - 1;
            r = s - q * p;
            if (2 * r > p || (2 * r == p && (q % 2) != 0)) q = q + 1;
            v = q;
        end else if (frac && drop < 0) begin
            v = s * (64'sd1 <<< (-drop));
        end
        lo = sgn ? -(64'sd1 <<< (w - 1)) : 64'sd0;
        hi = sgn ? (64'sd1 <<< (w - 1)) - 1 : (64'sd1 <<< w) - 1;
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        return v;
    endfunction

    task automatic step();
        longint acc;
        @(posedge clk);
        if (rst) begin
            s_a = 0; s_b = 0; s_c = 0; s_d = 0;
            o_a = 0; o_b = 0; o_c = 0; o_d = 0;
        end else if (ena) begin
            o_a = round_sat(s_a, 2, 1'b0, 8, 1'b1);
            o_b = round_sat(s_b, 0, 1'b1, 8, 1'b1);
            o_c = round_sat(s_c, 4, 1'b1, 4, 1'b1);
            o_d = round_sat(s_d, 2, 1'b0, 4, 1'b0);
            acc = 0; foreach (din_a[i]) acc += longint'($signed(din_a[i])); s_a = acc;
            acc = 0; foreach (din_b[i]) acc += longint'($signed(din_b[i])); s_b = acc;
            acc = 0; foreach (din_c[i]) acc += longint'($signed(din_c[i])); s_c = acc;
            acc = 0; foreach (din_d[i]) acc += longint'(din_d[i]);          s_d = acc;
        end
        #1;
        check_eq("model_a", longint'(dout_a), wrap(o_a, 8));
        check_eq("model_b", longint'(dout_b), wrap(o_b, 8));
        check_eq("model_c", longint'(dout_c), wrap(o_c, 4));
        check_eq("model_d", longint'(dout_d), wrap(o_d, 4));
    endtask

    task automatic drive_random();
        foreach (din_a[i]) din_a[i] = 8'($urandom);
        foreach (din_b[i]) din_b[i] = 8'($urandom);
        foreach (din_c[i]) din_c[i] = 8'($urandom);
        foreach (din_d[i]) din_d[i] = 4'($urandom);
    endtask

    // Directed vectors with their hand-computed results.
    int vec_a [5][4] = '{'{10, 20, 30, 4}, '{66, 0, 0, 0}, '{70, 0, 0, 0}, '{-6, 0, 0, 0}, '{-10, 0, 0, 0}};
    int exp_a [5]    = '{16, 16, 18, -2, -2};
    int vec_b [5][2] = '{'{64, -32}, '{100, 100}, '{-128, -128}, '{0, 0}, '{1, -1}};
    int exp_b [5]    = '{32, 127, -128, 0, 0};
    int vec_c [5][2] = '{'{24, 0}, '{40, 0}, '{56, 0}, '{127, 0}, '{-24, 0}};
    int exp_c [5]    = '{2, 2, 4, 7, -2};
    int vec_d [5][3] = '{'{15, 15, 15}, '{1, 1, 0}, '{3, 3, 0}, '{0, 0, 0}, '{15, 15, 14}};
    int exp_d [5]    = '{11, 0, 2, 0, 11};

    task automatic drive_vec(input int k);
        foreach (din_a[i]) din_a[i] = (k < 5) ? 8'(vec_a[k][i]) : 8'd0;
        foreach (din_b[i]) din_b[i] = (k < 5) ? 8'(vec_b[k][i]) : 8'd0;
        foreach (din_c[i]) din_c[i] = (k < 5) ? 8'(vec_c[k][i]) : 8'd0;
        foreach (din_d[i]) din_d[i] = (k < 5) ? 4'(vec_d[k][i]) : 4'd0;
    endtask

    initial begin
        s_a = 0; s_b = 0; s_c = 0; s_d = 0;
        o_a = 0; o_b = 0; o_c = 0; o_d = 0;
        rst = 1'b1;
        ena = 1'b0;
        drive_vec(5);
        step();
        step();
        check_eq("reset_a", longint'(dout_a), 0);
        check_eq("reset_d", longint'(dout_d), 0);

        // Directed vectors; result k appears two enabled edges after vector k.
        rst = 1'b0;
        ena = 1'b1;
        drive_vec(0);
        for (int k = 0; k < 6; k++) begin
            step();
            if (k == 0) begin
                check_eq("lat_a_edge1", longint'(dout_a), 0);
            end else begin
                check_eq("dir_a", longint'(dout_a), wrap(exp_a[k-1], 8));
                check_eq("dir_b", longint'(dout_b), wrap(exp_b[k-1], 8));
                check_eq("dir_c", longint'(dout_c), wrap(exp_c[k-1], 4));
                check_eq("dir_d", longint'(dout_d), wrap(exp_d[k-1], 4));
            end
            drive_vec(k + 1);
        end

        // Stall for three cycles mid-stream while inputs keep changing.
        drive_random();
        step();
        drive_random();
        step();
        ena = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_random();
            step();
        end
        ena = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive_random();
            step();
        end

        // Reset with ena high clears the pipe on the next edge.
        rst = 1'b1;
        drive_random();
        step();
        check_eq("rst_mid_a", longint'(dout_a), 0);
        check_eq("rst_mid_c", longint'(dout_c), 0);
        rst = 1'b0;

        // Random traffic with random stalls and occasional resets.
        for (int k = 0; k < 400; k++) begin
            drive_random();
            ena = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_input_round_adder.md
Name: multi_input_round_adder

Overview:
- Sums NUM_INPUT same-width operands, signed or unsigned, into a full-precision accumulator.
- Reduces the sum to WIDTH_OUT bits with unbiased round-half-to-even, then saturates.
- Two-stage registered pipeline: sum stage, then round/saturate stage.
- Used wherever a datapath combines several samples (filter taps, channel mixing) and must return to a narrower bus without DC bias.

Parameters:
- NUM_INPUT, 2: number of operands; must be >= 1.
- WIDTH_IN, 8: bit width of each operand; must be > 0.
- WIDTH_OUT, 8: output width; must be > 0.
- IS_SIGNED, 1: 1 = two's-complement operands and output; 0 = unsigned bit patterns.
- IS_FRACTION, 0: 0 = integer mode (keep MSBs of the full sum); 1 = fractional mode (binary point fixed relative to the input MSB).
- Any invalid parameter value is an elaboration-time $error.

Ports:
- clk, input, 1: single clock, rising-edge.
- rst, input, 1: reset, synchronous, active-high.
- ena, input, 1: pipeline clock enable.
- din, input, NUM_INPUT x WIDTH_IN (unpacked array): operands; reinterpreted as unsigned when IS_SIGNED=0.
- dout, output, WIDTH_OUT: rounded, saturated sum.

Behaviour:
- Full sum width WT = WIDTH_IN + $clog2(NUM_INPUT). With NUM_INPUT=1, WT = WIDTH_IN.
- Operands are sign-extended (IS_SIGNED=1) or zero-extended (IS_SIGNED=0) to WT before summing. The sum never overflows WT.
- Stage 1: sum_q <= sum(din) on a clk edge with ena=1.
- Stage 2: dout <= round_sat(sum_q) on a clk edge with ena=1.
- Latency is 2 enabled edges. ena=0 freezes both registers (stall, no bubble insertion).
- rst=1 clears sum_q and dout to 0 on the next edge. rst has priority over ena. Reset mid-stream discards in-flight data.
- Integer mode: D = WT - WIDTH_OUT.
  - D <= 0: dout = sign- or zero-extended sum.
  - D > 0: dout = round_half_even(sum / 2^D).
- Fractional mode: the binary point sits at the same weight for input and output.
  - D = WIDTH_IN - WIDTH_OUT fractional LSBs are dropped.
  - D < 0: append -D zero LSBs.
  - The clog2(NUM_INPUT) integer-growth bits are then removed by saturation.
- Round-half-to-even, applied only when D > 0:
  - guard = bit D-1; sticky = OR of bits D-2..0; lsb = bit D of the kept value.
  - Increment the kept value if guard & (sticky | lsb).
  - Rounding is symmetric for negative values (e.g. -1.5 -> -2, -2.5 -> -2).
  - Compute on the kept value extended by 1 bit so the carry is visible.
- Saturation, after rounding:
  - Signed result clamps to [-2^(WIDTH_OUT-1), 2^(WIDTH_OUT-1)-1].
  - Unsigned result clamps to [0, 2^WIDTH_OUT - 1].
  - Applies to rounding carry-out in both modes and to integer growth in fractional mode.
- All logic is synchronous; there are no combinational paths from din to dout.

Decomposition:
- Package num_pkg holds:
  - function sum_width(width, n) returning width + $clog2(n);
  - localparam helpers for signed/unsigned max and min values.
- One sub-module, round_half_even_sat.
  - Parameters: WIDTH_IN, WIDTH_OUT, IS_SIGNED, IS_FRACTION, FRAC_DROP.
  - Contains the registered stage 2.
- The adder stage lives in the top level.

Test Plan:
- Integer signed, N=4, WIDTH_IN=8, WIDTH_OUT=8 (D=2), ena=1:
  - din={10,20,30,4} (sum 64) -> dout=16 exactly two edges later.
  - sum 66 -> 16.
  - sum 70 -> 18.
  - sum -6 -> -2.
  - sum -10 -> -2.
- Fractional signed, N=2, WIDTH_IN=8, WIDTH_OUT=8:
  - 64 + (-32) -> 32.
  - 100 + 100 -> 127 (saturated).
  - -128 + -128 -> -128.
- Fractional signed, N=2, WIDTH_IN=8, WIDTH_OUT=4 (D=4):
  - sum 24 -> 2.
  - sum 40 -> 2.
  - sum 56 -> 4.
  - 127 + 0 -> 7 (rounding carry saturated).
- Unsigned integer, N=3, WIDTH_IN=4, WIDTH_OUT=4 (WT=6, D=2):
  - {15,15,15} (45) -> 11.
  - {1,1,0} (2) -> 0.
  - {3,3,0} (6) -> 2.
- Pipeline control:
  - ena low for 3 cycles mid-stream -> dout and sum_q hold, then resume with no loss or duplication.
  - rst asserted with ena=1 -> dout=0 the next edge.
  - The first valid output appears 2 enabled edges after rst deasserts.
